// File: rtl/config_multiplier_8bit_pkg.sv
// Shared types for the configurable 8x8 / dual 4x4 signed multiplier.
package config_multiplier_8bit_pkg;

  typedef enum logic {
    MODE_FULL   = 1'b0,
    MODE_HALVED = 1'b1
  } mode_e;

endpackage

// File: rtl/config_multiplier_8bit_mult_4x4_cfg.sv
// 4x4 multiplier whose operands are each individually treated as signed or unsigned.
module mult_4x4_cfg (
  input  logic              [3:0] a,
  input  logic              [3:0] b,
  input  logic                    a_signed,
  input  logic                    b_signed,
  output logic signed       [9:0] p
);

  localparam int LANE_W = 4;

  logic signed [LANE_W:0] a_ext;
  logic signed [LANE_W:0] b_ext;

  // A fifth bit makes both interpretations fit one signed 5x5 multiply.
  assign a_ext = {a_signed & a[LANE_W-1], a};
  assign b_ext = {b_signed & b[LANE_W-1], b};
  assign p     = a_ext * b_ext;

endmodule

// File: rtl/config_multiplier_8bit.sv
// Registered signed 8x8 multiplier, or two independent signed 4x4 lanes when halvedPrecision=1.
module config_multiplier_8bit
  import config_multiplier_8bit_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic signed  [7:0] multiplier,
  input  logic signed  [7:0] multiplicand,
  input  logic               halvedPrecision,
  output logic signed [15:0] product
);

  localparam int LANE_W = 4;
  localparam int OP_W   = 8;

  mode_e mode;
  assign mode = mode_e'(halvedPrecision);

  logic [LANE_W-1:0] a_hi, a_lo, b_hi, b_lo;
  assign a_hi = multiplier[OP_W-1:LANE_W];
  assign a_lo = multiplier[LANE_W-1:0];
  assign b_hi = multiplicand[OP_W-1:LANE_W];
  assign b_lo = multiplicand[LANE_W-1:0];

  logic full;
  assign full = (mode == MODE_FULL);

  // Cross terms see zero operands in halved mode so they contribute nothing.
  logic [LANE_W-1:0] hl_a, hl_b, lh_a, lh_b;
  assign hl_a = full ? a_hi : '0;
  assign hl_b = full ? b_lo : '0;
  assign lh_a = full ? a_lo : '0;
  assign lh_b = full ? b_hi : '0;

  logic signed [9:0] pp_hh, pp_hl, pp_lh, pp_ll;

  mult_4x4_cfg u_hh (
    .a        (a_hi),
    .b        (b_hi),
    .a_signed (1'b1),
    .b_signed (1'b1),
    .p        (pp_hh)
  );

  mult_4x4_cfg u_hl (
    .a        (hl_a),
    .b        (hl_b),
    .a_signed (1'b1),
    .b_signed (1'b0),
    .p        (pp_hl)
  );

  mult_4x4_cfg u_lh (
    .a        (lh_a),
    .b        (lh_b),
    .a_signed (1'b0),
    .b_signed (1'b1),
    .p        (pp_lh)
  );

  // Low nibbles are magnitude bits of a full operand but signed lanes in halved mode.
  mult_4x4_cfg u_ll (
    .a        (a_lo),
    .b        (b_lo),
    .a_signed (~full),
    .b_signed (~full),
    .p        (pp_ll)
  );

  logic signed [15:0] hh_ext, hl_ext, lh_ext, ll_ext;
  assign hh_ext = {{6{pp_hh[9]}}, pp_hh};
  assign hl_ext = {{6{pp_hl[9]}}, pp_hl};
  assign lh_ext = {{6{pp_lh[9]}}, pp_lh};
  assign ll_ext = {{6{pp_ll[9]}}, pp_ll};

  logic signed [15:0] full_sum;
  logic signed [15:0] halved_cat;
  logic signed [15:0] product_d;

  assign full_sum   = (hh_ext <<< 8) + ((hl_ext + lh_ext) <<< 4) + ll_ext;
  assign halved_cat = {pp_hh[7:0], pp_ll[7:0]};
  assign product_d  = full ? full_sum : halved_cat;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      product <= '0;
    end else begin
      product <= product_d;
    end
  end

endmodule

// File: tb/tb_config_multiplier_8bit.sv
// Directed-table, random back-to-back and mid-stream reset checks for config_multiplier_8bit.
module tb_config_multiplier_8bit;

  logic               clk;
  logic               rst_n;
  logic signed  [7:0] multiplier;
  logic signed  [7:0] multiplicand;
  logic               halvedPrecision;
  logic signed [15:0] product;

  int n_cmp;
  int n_err;
  logic [15:0] exp_q[$];

  config_multiplier_8bit dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .multiplier      (multiplier),
    .multiplicand    (multiplicand),
    .halvedPrecision (halvedPrecision),
    .product         (product)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string      name;
    logic [7:0] a;
    logic [7:0] b;
    logic       h;
    logic [15:0] exp;
  } vec_t;

  vec_t vecs[12];

  function automatic logic [15:0] model(input logic [7:0] a, input logic [7:0] b,
                                        input logic h);
    logic signed [15:0] sa, sb, full;
    logic signed [7:0]  ah, al, bh, bl, ph, pl;
    if (!h) begin
      sa   = {{8{a[7]}}, a};
      sb   = {{8{b[7]}}, b};
      full = sa * sb;
      return full;
    end
    ah = {{4{a[7]}}, a[7:4]};
    al = {{4{a[3]}}, a[3:0]};
    bh = {{4{b[7]}}, b[7:4]};
    bl = {{4{b[3]}}, b[3:0]};
    ph = ah * bh;
    pl = al * bl;
    return {ph, pl};
  endfunction

  task automatic check(input string name, input logic [15:0] got, input logic [15:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // driver: drive at negedge, sample 1 time unit after the capturing posedge
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic h);
    @(negedge clk);
    multiplier      = a;
    multiplicand    = b;
    halvedPrecision = h;
  endtask

  task automatic apply_and_check(input string name, input logic [7:0] a,
                                 input logic [7:0] b, input logic h,
                                 input logic [15:0] exp);
    drive(a, b, h);
    @(posedge clk);
    #1;
    check(name, product, exp);
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    rst_n = 1'b0;
    multiplier = 8'sd5;
    multiplicand = 8'sd7;
    halvedPrecision = 1'b0;

    vecs[0]  = '{"f_0x0",      8'h00, 8'h00, 1'b0, 16'h0000};
    vecs[1]  = '{"f_1x2",      8'h01, 8'h02, 1'b0, 16'h0002};
    vecs[2]  = '{"f_127x127",  8'h7F, 8'h7F, 1'b0, 16'h3F01};
    vecs[3]  = '{"f_m1x5",     8'hFF, 8'h05, 1'b0, 16'hFFFB};
    vecs[4]  = '{"f_m1xm1",    8'hFF, 8'hFF, 1'b0, 16'h0001};
    vecs[5]  = '{"f_m128xm1",  8'h80, 8'hFF, 1'b0, 16'h0080};
    vecs[6]  = '{"f_m8x4",     8'hF8, 8'h04, 1'b0, 16'hFFE0};
    vecs[7]  = '{"f_m128xm128",8'h80, 8'h80, 1'b0, 16'h4000};
    vecs[8]  = '{"h_77x7m7",   8'h77, 8'h79, 1'b1, 16'h31CF};
    vecs[9]  = '{"h_m8m8xm87", 8'h88, 8'h87, 1'b1, 16'h40C8};
    vecs[10] = '{"h_13x24",    8'h13, 8'h24, 1'b1, 16'h020C};
    vecs[11] = '{"h_44xm22",   8'h44, 8'hE2, 1'b1, 16'hF808};

    // reset state, with clock running and non-zero inputs
    repeat (2) @(posedge clk);
    #1;
    check("reset_state", product, 16'h0000);
    @(negedge clk);
    rst_n = 1'b1;

    // directed table, then the same table back-to-back to exercise mode flips
    foreach (vecs[i])
      apply_and_check(vecs[i].name, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].exp);
    for (int i = 11; i >= 0; i--)
      apply_and_check({vecs[i].name, "_rev"}, vecs[i].a, vecs[i].b, vecs[i].h, vecs[i].exp);

    // 100 random back-to-back operations with random mode, against the model
    for (int i = 0; i < 100; i++) begin
      logic [7:0] ra, rb;
      logic       rh;
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      rh = 1'($urandom_range(0, 1));
      drive(ra, rb, rh);
      exp_q.push_back(model(ra, rb, rh));
      @(posedge clk);
      #1;
      check($sformatf("rand_%0d", i), product, exp_q.pop_front());
    end

    // mid-stream reset: clears without a clock edge and drops the in-flight result
    drive(8'h7F, 8'h7F, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async_clear", product, 16'h0000);
    @(posedge clk);
    #1;
    check("rst_held_over_edge", product, 16'h0000);
    drive(8'h88, 8'h87, 1'b1);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("rst_first_edge", product, 16'h40C8);
    apply_and_check("rst_next_full", 8'h80, 8'h80, 1'b0, 16'h4000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
